// File: rtl/posit_fmau_pkg.sv
// Shared types and constants for the posit FMAU issue stage.
package posit_fmau_pkg;

    localparam int POSIT_W = 32;
    localparam int PRE_W   = 2;
    localparam logic [POSIT_W-1:0] POSIT_NAR = 32'h8000_0000;

    // One queued operation: four posit operands plus precision selects.
    typedef struct packed {
        logic [POSIT_W-1:0] a;
        logic [POSIT_W-1:0] b;
        logic [POSIT_W-1:0] c;
        logic [POSIT_W-1:0] d;
        logic [PRE_W-1:0]   ipre;
        logic [PRE_W-1:0]   opre;
    } fmau_bundle_t;

    localparam int BUNDLE_W = $bits(fmau_bundle_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } issue_state_t;

endpackage

// File: rtl/posit_fmau_issue_if.sv
// Operand-source and result-sink handshake bundle for the issue stage.
interface posit_fmau_issue_if;
    import posit_fmau_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [POSIT_W-1:0] in_a;
    logic [POSIT_W-1:0] in_b;
    logic [POSIT_W-1:0] in_c;
    logic [POSIT_W-1:0] in_d;
    logic [PRE_W-1:0]   in_ipre;
    logic [PRE_W-1:0]   in_opre;
    logic               res_valid;
    logic               res_ready;
    logic [POSIT_W-1:0] res_data;
    logic               res_err;

    // Master: the operand producer / result consumer.
    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_ipre, in_opre, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    // Slave: the issue stage itself.
    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_ipre, in_opre, res_ready,
        output in_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/posit_fmau_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head entry is read combinationally.
module posit_fmau_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Full blocks a push even when a pop happens in the same cycle.
    assign wr_en   = push & ~full;
    assign rd_en   = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; wraps naturally through the extra MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/posit_fmau_issue.sv
// Issue stage in front of the posit FMAU: queues operand bundles, launches one op at a
// time, holds operands until completion and captures the result (or a watchdog NaR).
module posit_fmau_issue
    import posit_fmau_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    posit_fmau_issue_if.slave  bus,
    output logic               fmau_start,
    output logic [POSIT_W-1:0] fmau_a,
    output logic [POSIT_W-1:0] fmau_b,
    output logic [POSIT_W-1:0] fmau_c,
    output logic [POSIT_W-1:0] fmau_d,
    output logic [PRE_W-1:0]   fmau_in_pre,
    output logic [PRE_W-1:0]   fmau_out_pre,
    input  logic [POSIT_W-1:0] fmau_out,
    input  logic               fmau_soe,
    output logic               busy
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    issue_state_t       state;
    fmau_bundle_t       in_bundle;
    fmau_bundle_t       head;
    fmau_bundle_t       ops;
    logic [BUNDLE_W-1:0] fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [WD_W-1:0]    wdog;

    assign in_bundle = '{a: bus.in_a, b: bus.in_b, c: bus.in_c, d: bus.in_d,
                         ipre: bus.in_ipre, opre: bus.in_opre};
    assign head      = fmau_bundle_t'(fifo_rd);
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    posit_fmau_fifo #(.DEPTH(DEPTH), .WIDTH(BUNDLE_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid),
        .wr_data (in_bundle),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.in_ready = ~fifo_full;
    assign busy         = (state != IDLE) || !fifo_empty;

    assign fmau_a       = ops.a;
    assign fmau_b       = ops.b;
    assign fmau_c       = ops.c;
    assign fmau_d       = ops.d;
    assign fmau_in_pre  = ops.ipre;
    assign fmau_out_pre = ops.opre;

    // Issue FSM: pop/launch, wait for soe or watchdog, hold result until consumed.
    // soe is only looked at in WAIT so a stray strobe from an unreset FMAU cannot land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            fmau_start    <= 1'b0;
            ops           <= '0;
            wdog          <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        ops        <= head;
                        fmau_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    fmau_start <= 1'b0;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (fmau_soe) begin
                        bus.res_data  <= fmau_out;
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= HOLD;
                    end else if (wdog == WD_LAST) begin
                        bus.res_data  <= POSIT_NAR;
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        wdog <= wdog + WD_ONE;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_fmau_issue.sv
// Bench for posit_fmau_issue: directed operations against a queue-based model with an
// FMAU responder that returns a chosen result after a chosen delay (0 = never).
module tb_posit_fmau_issue;
    import posit_fmau_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [31:0] a, b, c, d;
        logic [1:0]  ipre, opre;
        int          lat;
        logic [31:0] out;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fmau_start;
    logic [31:0] fmau_a, fmau_b, fmau_c, fmau_d;
    logic [1:0]  fmau_in_pre, fmau_out_pre;
    logic [31:0] fmau_out;
    logic        fmau_soe;
    logic        busy;

    posit_fmau_issue_if bus();

    always #5 clk = ~clk;

    posit_fmau_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .fmau_start   (fmau_start),
        .fmau_a       (fmau_a),
        .fmau_b       (fmau_b),
        .fmau_c       (fmau_c),
        .fmau_d       (fmau_d),
        .fmau_in_pre  (fmau_in_pre),
        .fmau_out_pre (fmau_out_pre),
        .fmau_out     (fmau_out),
        .fmau_soe     (fmau_soe),
        .busy         (busy)
    );

    int  vectors = 0;
    int  errors  = 0;
    op_t pend_q[$];
    int  starts    = 0;
    bit  stray_req = 1'b0;

    task automatic check(string name, logic [135:0] act, logic [135:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(logic [31:0] a, b, c, d, logic [1:0] ip, op, int lat, logic [31:0] out);
        op_t o;
        o.a = a; o.b = b; o.c = c; o.d = d; o.ipre = ip; o.opre = op; o.lat = lat; o.out = out;
        return o;
    endfunction

    // Model + FMAU responder + per-cycle comparison, all at the falling edge.
    initial begin
        op_t         cur;
        bit          inflight = 1'b0;
        bit          res_pend = 1'b0;
        bit          started;
        bit          exp_rv;
        int          cyc = 0;
        int          due = 0;
        int          cd = 0;
        logic [31:0] exp_data = '0;
        logic        exp_err = 1'b0;
        fmau_soe = 1'b0;
        fmau_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                inflight = 1'b0; res_pend = 1'b0; cd = 0;
                pend_q.delete();
                fmau_soe = 1'b0;
                continue;
            end
            started = 1'b0;
            if (fmau_start) begin
                check("one_in_flight", {135'd0, inflight}, 136'd0);
                if (pend_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL start_without_work: got start with empty model queue");
                end else begin
                    cur = pend_q.pop_front();
                    check("start_ops", {fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre},
                          {cur.a, cur.b, cur.c, cur.d, cur.ipre, cur.opre});
                    inflight = 1'b1; started = 1'b1; starts++;
                    cd       = cur.lat;
                    res_pend = 1'b1;
                    if (cur.lat >= 1 && cur.lat <= TIMEOUT) begin
                        due = cyc + cur.lat + 1; exp_data = cur.out; exp_err = 1'b0;
                    end else begin
                        due = cyc + TIMEOUT + 1; exp_data = POSIT_NAR; exp_err = 1'b1;
                    end
                end
            end else if (inflight) begin
                check("ops_stable", {fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre},
                      {cur.a, cur.b, cur.c, cur.d, cur.ipre, cur.opre});
            end
            check("in_ready", {135'd0, bus.in_ready}, {135'd0, pend_q.size() < DEPTH});
            check("busy", {135'd0, busy}, {135'd0, inflight || pend_q.size() > 0});
            exp_rv = res_pend && (cyc >= due);
            check("res_valid", {135'd0, bus.res_valid}, {135'd0, exp_rv});
            if (bus.res_valid && exp_rv) begin
                check("res_data", {104'd0, bus.res_data}, {104'd0, exp_data});
                check("res_err", {135'd0, bus.res_err}, {135'd0, exp_err});
                if (bus.res_ready) begin
                    res_pend = 1'b0; inflight = 1'b0;
                end
            end
            fmau_soe = 1'b0;
            if (!started && cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fmau_soe = 1'b1; fmau_out = cur.out;
                end
            end
            if (stray_req) begin
                fmau_soe = 1'b1; fmau_out = 32'hDEAD_BEEF; stray_req = 1'b0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(op_t op);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_a = op.a; bus.in_b = op.b; bus.in_c = op.c; bus.in_d = op.d;
        bus.in_ipre = op.ipre; bus.in_opre = op.opre;
        for (int i = 0; i < 300; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) pend_q.push_back(op);
            #1;
            if (acc) begin bus.in_valid = 1'b0; return; end
        end
        bus.in_valid = 1'b0;
        vectors++; errors++;
        $display("FAIL push_timeout: got in_ready low for 300 cycles expected accept");
    endtask

    task automatic wait_rv(string nm);
        for (int i = 0; i < 200; i++) begin
            if (bus.res_valid) return;
            tick(1);
        end
        vectors++; errors++;
        $display("FAIL %s: got no res_valid within 200 cycles expected result", nm);
    endtask

    task automatic wait_idle(string nm);
        for (int i = 0; i < 500; i++) begin
            if (!busy && !bus.res_valid) return;
            tick(1);
        end
        vectors++; errors++;
        $display("FAIL %s: got busy after 500 cycles expected idle", nm);
    endtask

    task automatic check_reset_vals(string nm);
        check({nm, "_in_ready"}, {135'd0, bus.in_ready}, 136'd1);
        check({nm, "_start"}, {135'd0, fmau_start}, 136'd0);
        check({nm, "_ops"}, {fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre}, 136'd0);
        check({nm, "_res_valid"}, {135'd0, bus.res_valid}, 136'd0);
        check({nm, "_res_data"}, {104'd0, bus.res_data}, 136'd0);
        check({nm, "_res_err"}, {135'd0, bus.res_err}, 136'd0);
        check({nm, "_busy"}, {135'd0, busy}, 136'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int s0;
        bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
        bus.in_ipre = '0; bus.in_opre = '0;
        #23;
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);

        // Single op: start exactly 2 cycles after the push is offered.
        s0 = starts;
        push(mk(32'hEC5A5A5A, 32'h5A5A5A5A, 32'h6D5B5ADA, 32'h5A525A7A, 2'b00, 2'b00, 5, 32'h1234_5678));
        check("min_lat_before", {135'd0, fmau_start}, 136'd0);
        tick(1);
        check("min_lat_start", {135'd0, fmau_start}, 136'd1);
        check("start_ops_lit", {fmau_a, fmau_b, fmau_c, fmau_d, fmau_in_pre, fmau_out_pre},
              {32'hEC5A5A5A, 32'h5A5A5A5A, 32'h6D5B5ADA, 32'h5A525A7A, 4'h0});
        wait_rv("single_wait");
        check("single_data", {104'd0, bus.res_data}, {104'd0, 32'h1234_5678});
        check("single_err", {135'd0, bus.res_err}, 136'd0);
        bus.res_ready = 1'b1;
        wait_idle("single_idle");
        check("single_starts", 136'(starts - s0), 136'd1);

        // Back-to-back: five ops fill the FIFO while the first is in flight.
        s0 = starts;
        push(mk(32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 32'h4444_0001, 2'b01, 2'b10, 3, 32'hA000_0001));
        push(mk(32'h1111_0002, 32'h2222_0002, 32'h3333_0002, 32'h4444_0002, 2'b10, 2'b01, 1, 32'hA000_0002));
        push(mk(32'h1111_0003, 32'h2222_0003, 32'h3333_0003, 32'h4444_0003, 2'b11, 2'b11, 7, 32'hA000_0003));
        push(mk(32'h1111_0004, 32'h2222_0004, 32'h3333_0004, 32'h4444_0004, 2'b00, 2'b11, 2, 32'hA000_0004));
        push(mk(32'h1111_0005, 32'h2222_0005, 32'h3333_0005, 32'h4444_0005, 2'b01, 2'b00, 4, 32'hA000_0005));
        check("b2b_full", {135'd0, bus.in_ready}, 136'd0);
        wait_idle("b2b_idle");
        check("b2b_starts", 136'(starts - s0), 136'd5);

        // Timeout: FMAU never answers.
        bus.res_ready = 1'b0;
        push(mk(32'h0BAD_0BAD, 32'h1, 32'h2, 32'h3, 2'b00, 2'b01, 0, 32'h0));
        wait_rv("timeout_wait");
        check("timeout_data", {104'd0, bus.res_data}, {104'd0, 32'h8000_0000});
        check("timeout_err", {135'd0, bus.res_err}, 136'd1);
        bus.res_ready = 1'b1;
        wait_idle("timeout_idle");

        // Backpressure: result held, no further launch while consumer stalls.
        bus.res_ready = 1'b0;
        push(mk(32'hC000_0001, 32'h5, 32'h6, 32'h7, 2'b01, 2'b01, 2, 32'hB000_0001));
        push(mk(32'hC000_0002, 32'h5, 32'h6, 32'h7, 2'b10, 2'b10, 2, 32'hB000_0002));
        push(mk(32'hC000_0003, 32'h5, 32'h6, 32'h7, 2'b11, 2'b00, 2, 32'hB000_0003));
        wait_rv("bp_wait");
        s0 = starts;
        tick(10);
        check("bp_no_start", 136'(starts - s0), 136'd0);
        check("bp_data", {104'd0, bus.res_data}, {104'd0, 32'hB000_0001});
        bus.res_ready = 1'b1;
        wait_idle("bp_idle");

        // Stray soe while idle must not produce a result.
        stray_req = 1'b1;
        tick(3);
        check("stray_idle", {135'd0, bus.res_valid}, 136'd0);

        // soe on the last watchdog cycle wins; one cycle later is too late.
        push(mk(32'hD000_0001, 32'h9, 32'hA, 32'hB, 2'b00, 2'b00, TIMEOUT, 32'hABCD_0001));
        push(mk(32'hD000_0002, 32'h9, 32'hA, 32'hB, 2'b00, 2'b00, TIMEOUT + 1, 32'hABCD_0002));
        wait_idle("edge_idle");

        // Reset in the middle of WAIT, then a late strobe.
        bus.res_ready = 1'b0;
        push(mk(32'hE000_0001, 32'h1, 32'h1, 32'h1, 2'b10, 2'b10, 8, 32'hEEEE_0001));
        tick(4);
        #2 rst = 1'b1;
        #1 check_reset_vals("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        stray_req = 1'b1;
        tick(3);
        check("post_reset_rv", {135'd0, bus.res_valid}, 136'd0);
        check("post_reset_busy", {135'd0, busy}, 136'd0);
        check("drain", 136'(pend_q.size()), 136'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
